// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Covers the loader FSM state encoding and the default frame sync byte.
package imem_loader_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StDataLo,
        StDataHi,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    localparam logic [7:0]  SyncByteDefault = 8'hA5;
    localparam int unsigned WordW           = 16;

endpackage

// File: rtl/imem_loader_fsm.sv
// Frame-parsing control FSM for imem_loader: state register, next-state and output decode.
// The timeout input is tied low by the top unless IMEM_LOADER_TIMEOUT_EN is defined.
module imem_loader_fsm
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    input  logic [15:0] count_i,
    input  logic [15:0] words_loaded_i,
    input  logic [7:0]  checksum_i,
    input  logic        timeout_i,
    output state_e      state_o,
    output logic        accept_o,
    output logic        in_ready_o,
    output logic        imem_we_o,
    output logic        cpu_hold_o,
    output logic        load_done_o,
    output logic        load_error_o
);

    state_e      state_q, state_d;
    logic        done_q, done_d;
    logic [15:0] new_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        new_count = {in_data_i, count_i[7:0]};
        case (state_q)
            StIdle, StDone, StError: begin
                if (accept_o && in_data_i == SYNC_BYTE) state_d = StCntLo;
            end
            StCntLo:  if (accept_o) state_d = StCntHi;
            StCntHi: begin
                if (accept_o) begin
                    if (32'(new_count) > MEM_DEPTH) state_d = StError;
                    else if (new_count == 16'd0)    state_d = StCheck;
                    else                            state_d = StDataLo;
                end
            end
            StDataLo: if (accept_o) state_d = StDataHi;
            StDataHi: if (accept_o) state_d = StWrite;
            StWrite: begin
                state_d = (words_loaded_i + 16'd1 == count_i) ? StCheck : StDataLo;
            end
            StCheck: begin
                if (accept_o) begin
                    if (in_data_i == checksum_i) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A stalled stream aborts the frame from any byte-waiting state.
        if (timeout_i && state_q inside {StCntLo, StCntHi, StDataLo, StDataHi, StCheck}) begin
            state_d = StError;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        state_o      = state_q;
        in_ready_o   = (state_q != StWrite);
        accept_o     = in_valid_i && in_ready_o;
        imem_we_o    = (state_q == StWrite);
        cpu_hold_o   = (state_q != StDone);
        load_done_o  = done_q;
        load_error_o = (state_q == StError);
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: parses frames, writes 16-bit words, gates cpu_hold.
// Define IMEM_LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter logic [7:0]  SYNC_BYTE   = SyncByteDefault,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [WordW-1:0]  imem_wdata_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_error_o,
    output logic [15:0]       words_loaded_o
);

    state_e            state;
    logic              accept;
    logic              timeout;
    logic [15:0]       count_q, count_d;
    logic [7:0]        checksum_q, checksum_d;
    logic [7:0]        lo_q, lo_d, hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       words_q, words_d;

    imem_loader_fsm #(
        .MEM_DEPTH (MEM_DEPTH),
        .SYNC_BYTE (SYNC_BYTE)
    ) u_fsm (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .in_valid_i     (in_valid_i),
        .in_data_i      (in_data_i),
        .count_i        (count_q),
        .words_loaded_i (words_q),
        .checksum_i     (checksum_q),
        .timeout_i      (timeout),
        .state_o        (state),
        .accept_o       (accept),
        .in_ready_o     (in_ready_o),
        .imem_we_o      (imem_we_o),
        .cpu_hold_o     (cpu_hold_o),
        .load_done_o    (load_done_o),
        .load_error_o   (load_error_o)
    );

    always_comb begin
        count_d    = count_q;
        checksum_d = checksum_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        words_d    = words_q;
        case (state)
            StIdle, StDone, StError: begin
                if (accept && in_data_i == SYNC_BYTE) begin
                    checksum_d = 8'h00;
                    addr_d     = '0;
                    words_d    = 16'd0;
                end
            end
            StCntLo:  if (accept) count_d[7:0]  = in_data_i;
            StCntHi:  if (accept) count_d[15:8] = in_data_i;
            StDataLo: if (accept) lo_d = in_data_i;
            StDataHi: if (accept) hi_d = in_data_i;
            StWrite: begin
                addr_d  = addr_q + ADDR_W'(1);
                words_d = words_q + 16'd1;
            end
            default: ;
        endcase
        if (accept && state inside {StCntLo, StCntHi, StDataLo, StDataHi}) begin
            checksum_d = checksum_q ^ in_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q    <= 16'd0;
            checksum_q <= 8'h00;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            addr_q     <= '0;
            words_q    <= 16'd0;
        end else begin
            count_q    <= count_d;
            checksum_q <= checksum_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
        end
    end

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        case (state)
            StCntLo, StCntHi, StDataLo, StDataHi, StCheck: begin
                tmo_d = accept ? '0 : tmo_q + TmoW'(1);
            end
            StWrite: tmo_d = tmo_q;
            default: tmo_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end

    assign timeout = (tmo_q == TmoW'(TIMEOUT_CYC));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    assign imem_addr_o    = addr_q;
    assign imem_wdata_o   = {hi_q, lo_q};
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Table-driven bench for imem_loader: per-cycle input/expected-output records plus
// hand-written reset checks, including a reset in the middle of a frame.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic        imem_we_o;
    logic [9:0]  imem_addr_o;
    logic [15:0] imem_wdata_o;
    logic        cpu_hold_o;
    logic        load_done_o;
    logic        load_error_o;
    logic [15:0] words_loaded_o;

    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .in_valid_i     (in_valid_i),
        .in_data_i      (in_data_i),
        .in_ready_o     (in_ready_o),
        .imem_we_o      (imem_we_o),
        .imem_addr_o    (imem_addr_o),
        .imem_wdata_o   (imem_wdata_o),
        .cpu_hold_o     (cpu_hold_o),
        .load_done_o    (load_done_o),
        .load_error_o   (load_error_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        rdy;
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wd;
        logic        hold;
        logic        done;
        logic        err;
        logic [15:0] wl;
    } vec_t;

    vec_t vq[$];

    // Expected values describe the outputs during the cycle the row's input is presented.
    function automatic void add(input logic v, input logic [7:0] d, input logic rdy,
                                input logic we, input logic [9:0] a, input logic [15:0] wd,
                                input logic hold, input logic done, input logic err,
                                input logic [15:0] wl);
        vec_t r;
        r.valid = v;   r.data = d;  r.rdy = rdy; r.we = we;   r.addr = a;
        r.wd    = wd;  r.hold = hold; r.done = done; r.err = err; r.wl = wl;
        vq.push_back(r);
    endfunction

    // Two-word frame 0x1234, 0xABCD with in_valid held high throughout.
    function automatic void add_frame(input logic hold0, input logic err0,
                                      input logic [15:0] wl0, input logic [7:0] chk,
                                      input logic good);
        add(1, 8'hA5, 1, 0, 0, 0, hold0, 0, err0, wl0);
        add(1, 8'h02, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h34, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h12, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'hCD, 0, 1, 10'd0, 16'h1234, 1, 0, 0, 0);
        add(1, 8'hCD, 1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 8'hAB, 1, 0, 0, 0, 1, 0, 0, 1);
        add(1, chk,   0, 1, 10'd1, 16'hABCD, 1, 0, 0, 1);
        add(1, chk,   1, 0, 0, 0, 1, 0, 0, 2);
        if (good) begin
            add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 2);
            add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2);
        end else begin
            add(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 2);
            add(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 2);
        end
    endfunction

    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            @(negedge clk_i);
            checks++;
            if (in_ready_o !== vq[i].rdy || imem_we_o !== vq[i].we ||
                cpu_hold_o !== vq[i].hold || load_done_o !== vq[i].done ||
                load_error_o !== vq[i].err || words_loaded_o !== vq[i].wl ||
                (vq[i].we && (imem_addr_o !== vq[i].addr || imem_wdata_o !== vq[i].wd))) begin
                errors++;
                $display("FAIL %s row %0d: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b wl=%0d, want rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b wl=%0d",
                         tag, i, in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o,
                         load_done_o, load_error_o, words_loaded_o, vq[i].rdy, vq[i].we,
                         vq[i].addr, vq[i].wd, vq[i].hold, vq[i].done, vq[i].err, vq[i].wl);
            end
            in_valid_i = vq[i].valid;
            in_data_i  = vq[i].data;
        end
        vq.delete();
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (in_ready_o !== 1'b1 || imem_we_o !== 1'b0 || imem_addr_o !== 10'd0 ||
            imem_wdata_o !== 16'h0000 || cpu_hold_o !== 1'b1 || load_done_o !== 1'b0 ||
            load_error_o !== 1'b0 || words_loaded_o !== 16'd0) begin
            errors++;
            $display("FAIL %s: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b wl=%0d, want rdy=1 we=0 addr=000 wd=0000 hold=1 done=0 err=0 wl=0",
                     tag, in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o,
                     load_done_o, load_error_o, words_loaded_o);
        end
    endtask

    initial begin
        reset_i    = 1'b1;
        in_valid_i = 1'b0;
        in_data_i  = 8'h00;
        @(negedge clk_i);
        check_reset_values("reset_state");
        @(negedge clk_i);
        reset_i = 1'b0;

        // Good frame, bad checksum, zero-count, oversized count, garbage then good frame.
        add_frame(1, 0, 0, 8'h42, 1);
        add_frame(0, 0, 2, 8'h43, 0);
        add(1, 8'hA5, 1, 0, 0, 0, 1, 0, 1, 2);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
        add(1, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h04, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0);
        add(1, 8'h11, 1, 0, 0, 0, 1, 0, 1, 0);
        add(1, 8'h22, 1, 0, 0, 0, 1, 0, 1, 0);
        add_frame(1, 1, 0, 8'h42, 1);
        run_vecs("table");

        // One-word frame interrupted by reset after its word is written.
        add(1, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 2);
        add(1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h77, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h66, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 10'd0, 16'h6677, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1);
        run_vecs("pre_reset");
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check_reset_values("mid_frame_reset");
        @(negedge clk_i);
        check_reset_values("reset_held");
        reset_i = 1'b0;

        // Fresh frame after reset, with an idle gap in DATA_LO; must rewrite address 0.
        add(1, 8'hA5, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 8'hEF, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'hEF, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'hBE, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h50, 0, 1, 10'd0, 16'hBEEF, 1, 0, 0, 0);
        add(1, 8'h50, 1, 0, 0, 0, 1, 0, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1);
        run_vecs("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the fetch stage reads.
- Receives a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word sequentially into the instruction memory write port from address 0.
- Holds the processor stalled via cpu_hold until a load completes with a good checksum.

Parameters:
- ADDR_W, 10, instruction memory address width in words.
- MEM_DEPTH, 1024, number of writable words; a frame with count > MEM_DEPTH is rejected.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1000, inter-byte timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts byte; a transfer occurs when in_valid && in_ready at a rising edge.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  16  instruction word.
- cpu_hold  out  1  high keeps the processor stalled.
- load_done  out  1  one-cycle pulse on successful load.
- load_error  out  1  level; high in ERROR state.
- words_loaded  out  16  words written in the current or last frame.

Behaviour:
Reset (asynchronous, active-high), all outputs:
- State IDLE; in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
- cpu_hold=1, load_done=0, load_error=0, words_loaded=0.
- Internal count=0, checksum=0.

Frame format:
- SYNC_BYTE, CNT_LO, CNT_HI, then count words each sent low byte then high byte, then CHK.
- CHK is the XOR of every byte after SYNC_BYTE up to and excluding CHK.

States:
- IDLE: accept bytes; non-sync bytes are dropped. SYNC_BYTE -> CNT_LO; clear checksum, words_loaded and address; assert cpu_hold.
- CNT_LO -> CNT_HI on one byte.
- CNT_HI on one byte:
  - count > MEM_DEPTH -> ERROR.
  - count == 0 -> CHECK.
  - otherwise -> DATA_LO.
- DATA_LO: latch low byte -> DATA_HI.
- DATA_HI: latch high byte -> WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, imem_we=1, imem_addr=current address, imem_wdata={hi,lo}.
  - Next cycle: address increments and words_loaded increments.
  - -> CHECK if words_loaded+1 == count, else -> DATA_LO.
- CHECK: accept one byte.
  - Equal to the running checksum -> DONE, load_done pulses 1 cycle, cpu_hold falls the same cycle.
  - Otherwise -> ERROR.
- DONE: cpu_hold=0, in_ready=1. SYNC_BYTE restarts the frame (-> CNT_LO, cpu_hold=1 next cycle); other bytes are dropped.
- ERROR: load_error=1, cpu_hold=1. SYNC_BYTE clears load_error and -> CNT_LO; other bytes are dropped.

Timing and boundary rules:
- Latency: the high byte is accepted at edge k, imem_we is high during cycle k+1, the next byte can be accepted at edge k+2.
- in_ready is low only in WRITE.
- The checksum updates on every accepted byte in CNT_LO..DATA_HI.
- The address wraps never: count ≤ MEM_DEPTH guarantees the last address is MEM_DEPTH-1. count == MEM_DEPTH is legal.
- A SYNC_BYTE value inside a frame is treated as data, not a restart.
- Reset mid-frame: immediate return to reset values. Already-written memory words are not cleared.
- imem_we never asserts outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_TIMEOUT_EN.
- When defined: a counter resets on every accepted byte and increments each cycle in CNT_LO..DATA_HI and CHECK. Reaching TIMEOUT_CYC forces ERROR.
- When undefined: no counter exists; the loader waits indefinitely for bytes.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum (IDLE, CNT_LO, CNT_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERROR).
  - SYNC_BYTE default.
  - word width constant 16.
- One natural sub-module: imem_loader_fsm (state register plus next-state/output decode). Datapath registers stay in the top.

Test Plan:
- Good frame A5,02,00,34,12,CD,AB,CHK=02^00^34^12^CD^AB=42:
  - imem_we pulses at addr 0 data 1234, then addr 1 data ABCD.
  - Then load_done pulses, cpu_hold=0, words_loaded=2.
- Same frame with CHK=43 -> load_error=1, cpu_hold stays 1, load_done never pulses.
- Zero-count frame A5,00,00,00 -> DONE with no imem_we; A5,01,04 (count 1025 > 1024) -> ERROR immediately.
- Garbage bytes 11,22 before A5, then a good frame -> garbage ignored, frame loads normally.
- in_valid held high continuously -> in_ready drops exactly one cycle after each high byte; no byte lost or duplicated.
- Reset asserted mid-frame after 1 word, then a fresh frame -> outputs at reset values; new frame rewrites from addr 0.
  - With IMEM_LOADER_TIMEOUT_EN: stall stream for TIMEOUT_CYC in DATA_LO -> ERROR.
